bram_delay: RTL and testbench
=============================

Name: bram_delay

Overview:
- Parametrised successor of the team's single-port byte-enable BRAM.
- Generalises data width, address width and access latency.
- Adds a valid/ready request handshake and a one-cycle response strobe, so firmware-visible external memory can be modelled with configurable wait states.
- Sits behind the user-project Wishbone/AXI adapter as the backing store for exmem experiments.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8 (≥8).
- ADDR_WIDTH, 22, byte-address width; depth = 2**ADDR_WIDTH bytes.
- DELAY, 10, cycles from request acceptance to response; valid range 1..255.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  DATA_WIDTH/8  byte write enables; all-zero = read.
- req_addr  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored (word aligned).
- req_wdata  input  DATA_WIDTH  write data, lane i = bits [8i+7:8i].
- rsp_valid  output  1  one-cycle response strobe (read data valid / write done).
- rsp_rdata  output  DATA_WIDTH  read data; zero whenever rsp_valid is low.

Behaviour:
- Reset (RSTN low, async):
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, req_ready=1 after reset.
  - Memory contents are not cleared.
- States:
  - IDLE: req_ready=1; accept on req_valid&&req_ready -> BUSY (DELAY>1) or RESP (DELAY=1).
  - BUSY: req_ready=0; counter loaded with DELAY-2 at acceptance, decrements each cycle; at 0 -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle; req_ready=1; new acceptance -> BUSY/RESP as above, else -> IDLE.
- Latency: request accepted at edge t -> rsp_valid high in cycle after edge t+DELAY-1, i.e. exactly DELAY cycles later. DELAY=1 gives full throughput, one access per cycle; DELAY=N gives one access per N cycles.
- Access at acceptance edge:
  - Word index = req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
  - Old word captured into a hold register; lanes with req_we[i]=1 written.
  - rsp_rdata = hold register during RESP, else 0.
- Write response returns old (pre-write) word data, read-first, unless the option is enabled.
- req_* inputs are sampled only at acceptance; changes during BUSY are ignored.
- req_valid while req_ready=0: no effect, no state change; the requester must hold it.
- Address wrap: addresses are modulo 2**ADDR_WIDTH, no out-of-range error.
- Reset mid-BUSY: pending response dropped; the write committed at acceptance remains in memory.
- Only one access is outstanding at any time; responses are in order by construction.

Optional Feature:
- Macro BRAM_DELAY_WRITE_FIRST_EN.
- Defined: rsp_rdata for a write access returns the merged word, with written lanes replaced by req_wdata and unwritten lanes old.
- Undefined: read-first, old word returned.
- Read accesses are identical in both builds.

Test Plan:
- Reset: RSTN low mid-sim -> rsp_valid=0, rsp_rdata=0, req_ready=1 immediately (async); after release, read of previously written addr 0x10 still returns its data.
- Basic latency, DELAY=10: write 0xDEADBEEF, we=4'hF to addr 0x100, then read 0x100 -> read rsp_valid exactly 10 cycles after acceptance, rsp_rdata=0xDEADBEEF; req_ready=0 for 9 cycles after each acceptance.
- Byte enables: write 0x11223344 we=4'hF then 0xAABBCCDD we=4'b0101 to 0x200 -> read returns 0x11BB33DD.
- Throughput, DELAY=1: back-to-back reads of 0x0,0x4,0x8 with req_valid held -> rsp_valid high three consecutive cycles, data in order; rsp_rdata=0 in the cycles around them.
- Wrap and alignment: ADDR_WIDTH=22, write to 0x3FFFFE -> stored at word 0x3FFFFC; read 0x3FFFFC returns same data.
- Option: write 0xCAFEF00D we=4'b0011 over 0x12345678 -> rsp_rdata=0x1234F00D with BRAM_DELAY_WRITE_FIRST_EN, 0x12345678 without.

Source files
------------

// File: rtl/bram_delay.sv
// Single-port byte-enable block RAM with a valid/ready request and a fixed DELAY-cycle response strobe.
// Optional macro BRAM_DELAY_WRITE_FIRST_EN: write responses return the merged word instead of the old one.
module bram_delay #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DELAY      = 10
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_WIDTH/8-1:0]   req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata
);

    localparam int unsigned LANES   = DATA_WIDTH / 8;
    localparam int unsigned OFFS    = $clog2(LANES);
    localparam int unsigned WORD_AW = ADDR_WIDTH - OFFS;
    localparam int unsigned WORDS   = 1 << WORD_AW;
    localparam logic [7:0]  CNT_INIT = (DELAY > 1) ? 8'(DELAY - 2) : 8'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // With DELAY=1 the access goes straight to the response cycle.
    localparam state_t ACCEPT_STATE = (DELAY > 1) ? BUSY : RESP;

    state_t                 state;
    state_t                 next_state;
    logic [7:0]             count;
    logic [DATA_WIDTH-1:0]  hold;
    logic [DATA_WIDTH-1:0]  old_word;
    logic [DATA_WIDTH-1:0]  new_word;
    logic [WORD_AW-1:0]     index;
    logic                   accept;
    logic                   unused_addr;

    logic [DATA_WIDTH-1:0]  mem [0:WORDS-1];

    assign index       = req_addr[ADDR_WIDTH-1:OFFS];
    assign unused_addr = ^req_addr;
    assign accept      = req_valid && req_ready;
    assign old_word    = mem[index];

    always_comb begin
        new_word = old_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (req_we[i]) new_word[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    // Memory contents survive reset, so the array sits in its own reset-free block.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (req_we[i]) mem[index][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            count <= '0;
            hold  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                count <= CNT_INIT;
`ifdef BRAM_DELAY_WRITE_FIRST_EN
                hold  <= new_word;
`else
                hold  <= old_word;
`endif
            end else if (state == BUSY && count != 8'd0) begin
                count <= count - 8'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        case (state)
            IDLE: begin
                if (req_valid) next_state = ACCEPT_STATE;
            end
            BUSY: begin
                req_ready = 1'b0;
                if (count == 8'd0) next_state = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = hold;
                next_state = req_valid ? ACCEPT_STATE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_delay.sv
// Directed self-checking bench for bram_delay: a DELAY=10 instance and a DELAY=1 throughput instance.
module tb_bram_delay;

    localparam int unsigned DLY_A = 10;

    logic        CLK;
    logic        RSTN;

    logic        a_valid, a_ready, a_rsp_valid;
    logic [3:0]  a_we;
    logic [21:0] a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_valid, b_ready, b_rsp_valid;
    logic [3:0]  b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    int unsigned n_checks;
    int unsigned n_fail;

    bram_delay #(.DATA_WIDTH(32), .ADDR_WIDTH(22), .DELAY(DLY_A)) dut_a (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata)
    );

    bram_delay #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DELAY(1)) dut_b (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on instance A, started #1 after a rising edge with the block idle.
    // Garbage is driven on req_* during BUSY to show it is ignored.
    task automatic acc_a(input string tag, input logic [3:0] we, input logic [21:0] addr,
                         input logic [31:0] wd, input bit chk, input logic [31:0] exp);
        int unsigned cyc;
        int unsigned busy_low;
        check({tag, "_ready_idle"}, 32'(a_ready), 32'd1);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        @(posedge CLK); #1;
        cyc = 1; busy_low = 0;
        a_we = 4'hF; a_wdata = ~wd;
        while (!a_rsp_valid && cyc < 40) begin
            if (!a_ready) busy_low++;
            if (cyc >= DLY_A - 1) a_valid = 1'b0;
            @(posedge CLK); #1;
            cyc++;
        end
        a_valid = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(DLY_A));
        check({tag, "_busy_cycles"}, 32'(busy_low), 32'(DLY_A - 1));
        check({tag, "_ready_resp"}, 32'(a_ready), 32'd1);
        if (chk) check({tag, "_rdata"}, a_rdata, exp);
        @(posedge CLK); #1;
        check({tag, "_strobe_off"}, 32'(a_rsp_valid), 32'd0);
        check({tag, "_rdata_off"}, a_rdata, 32'd0);
    endtask

    logic [31:0] tp_data [3];

    initial begin
        n_checks = 0; n_fail = 0;
        RSTN = 1'b0;
        a_valid = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
        tp_data[0] = 32'h01020304; tp_data[1] = 32'h55667788; tp_data[2] = 32'h9ABCDEF0;

        #3;
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        #9 RSTN = 1'b1;
        @(posedge CLK); #1;

        acc_a("wr10", 4'hF, 22'h000010, 32'hA5A50010, 1'b0, '0);
        acc_a("wr100", 4'hF, 22'h000100, 32'hDEADBEEF, 1'b0, '0);
        acc_a("rd100", 4'h0, 22'h000100, 32'h0, 1'b1, 32'hDEADBEEF);

        acc_a("wr200", 4'hF, 22'h000200, 32'h11223344, 1'b0, '0);
`ifdef BRAM_DELAY_WRITE_FIRST_EN
        acc_a("wr200_be", 4'b0101, 22'h000200, 32'hAABBCCDD, 1'b1, 32'h11BB33DD);
`else
        acc_a("wr200_be", 4'b0101, 22'h000200, 32'hAABBCCDD, 1'b1, 32'h11223344);
`endif
        acc_a("rd200", 4'h0, 22'h000200, 32'h0, 1'b1, 32'h11BB33DD);

        acc_a("wr_top", 4'hF, 22'h3FFFFE, 32'h5A5A1234, 1'b0, '0);
        acc_a("rd_top", 4'h0, 22'h3FFFFC, 32'h0, 1'b1, 32'h5A5A1234);
        acc_a("rd_top_odd", 4'h0, 22'h3FFFFF, 32'h0, 1'b1, 32'h5A5A1234);

        acc_a("wr40", 4'hF, 22'h000040, 32'h12345678, 1'b0, '0);
`ifdef BRAM_DELAY_WRITE_FIRST_EN
        acc_a("wr40_opt", 4'b0011, 22'h000040, 32'hCAFEF00D, 1'b1, 32'h1234F00D);
`else
        acc_a("wr40_opt", 4'b0011, 22'h000040, 32'hCAFEF00D, 1'b1, 32'h12345678);
`endif
        acc_a("rd40", 4'h0, 22'h000040, 32'h0, 1'b1, 32'h1234F00D);

        // Reset while a write to 0x10 is in flight: response dropped, write kept.
        a_valid = 1'b1; a_we = 4'hF; a_addr = 22'h000010; a_wdata = 32'h77778888;
        @(posedge CLK); #1;
        a_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("midbusy_ready_before", 32'(a_ready), 32'd0);
        RSTN = 1'b0;
        #1;
        check("midbusy_rst_valid", 32'(a_rsp_valid), 32'd0);
        check("midbusy_rst_rdata", a_rdata, 32'd0);
        check("midbusy_rst_ready", 32'(a_ready), 32'd1);
        repeat (2) @(posedge CLK);
        #2 RSTN = 1'b1;
        repeat (DLY_A + 2) begin
            @(posedge CLK); #1;
            check("midbusy_no_rsp", 32'(a_rsp_valid), 32'd0);
        end
        acc_a("rd10_after_rst", 4'h0, 22'h000010, 32'h0, 1'b1, 32'h77778888);

        // Full throughput on the DELAY=1 instance.
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_we = 4'hF; b_addr = 8'(4 * i); b_wdata = tp_data[i];
            @(posedge CLK); #1;
            check("tp_wr_valid", 32'(b_rsp_valid), 32'd1);
        end
        b_valid = 1'b0; b_we = '0;
        @(posedge CLK); #1;
        check("tp_gap_valid", 32'(b_rsp_valid), 32'd0);
        check("tp_gap_rdata", b_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_we = 4'h0; b_addr = 8'(4 * i); b_wdata = 32'hFFFFFFFF;
            check("tp_ready", 32'(b_ready), 32'd1);
            @(posedge CLK); #1;
            check("tp_rd_valid", 32'(b_rsp_valid), 32'd1);
            check("tp_rd_data", b_rdata, tp_data[i]);
        end
        b_valid = 1'b0;
        @(posedge CLK); #1;
        check("tp_end_valid", 32'(b_rsp_valid), 32'd0);
        check("tp_end_rdata", b_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
